// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_sequencer
// Purpose  : Multi-bit logical shift controller placed in front of a
//            single-bit ALU shift unit. It accepts one command (operand,
//            direction, amount) and runs it as repeated 1-bit shifts. Each
//            registered unit output is fed back as the next operand.
// Ports    : clk / rst_n         - clock, asynchronous active-low reset
//            cmd_valid_i/ready_o - command handshake (accept on valid&ready)
//            cmd_data_i/dir_i/amt_i - operand, 0=right 1=left, amount in bits
//            sh_a_o/sh_b_o/sh_fun_o/sh_en_o - drive the shift unit
//            sh_out_i/sh_out_valid_i       - registered shift-unit result
//            res_data_o/res_valid_o        - final result, 1-cycle pulse
//            busy_o              - command in progress
// Revision : 1.0 - initial release
// ============================================================================
module shift_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int AMT_WIDTH     = 4,
  parameter int ALU_FUN_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [DATA_WIDTH-1:0]    cmd_data_i,
  input  logic                     cmd_dir_i,
  input  logic [AMT_WIDTH-1:0]     cmd_amt_i,
  output logic [DATA_WIDTH-1:0]    sh_a_o,
  output logic [DATA_WIDTH-1:0]    sh_b_o,
  output logic [ALU_FUN_WIDTH-1:0] sh_fun_o,
  output logic                     sh_en_o,
  input  logic [DATA_WIDTH-1:0]    sh_out_i,
  input  logic                     sh_out_valid_i,
  output logic [DATA_WIDTH-1:0]    res_data_o,
  output logic                     res_valid_o,
  output logic                     busy_o
);

  // Counter must hold both any raw amount and the saturated value DATA_WIDTH.
  localparam int c_DW_BITS = $clog2(DATA_WIDTH + 1);
  localparam int c_CNT_W   = (AMT_WIDTH > c_DW_BITS) ? AMT_WIDTH : c_DW_BITS;
  localparam logic [c_CNT_W-1:0] c_DW_CNT = c_CNT_W'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_q;
  logic [DATA_WIDTH-1:0]    work_q;
  logic                     dir_q;
  logic [c_CNT_W-1:0]       remaining_q;
  logic [DATA_WIDTH-1:0]    res_data_q;
  logic                     res_valid_q;
  logic                     sh_en_q;
  logic [ALU_FUN_WIDTH-1:0] sh_fun_q;
  logic                     cmd_ready_q;
  logic                     busy_q;

  logic [c_CNT_W-1:0]       amt_ext;
  logic [c_CNT_W-1:0]       amt_sat;

  // Amounts at or beyond the operand width all produce zero, so they are
  // capped at DATA_WIDTH iterations.
  always_comb begin
    amt_ext = c_CNT_W'(cmd_amt_i);
    amt_sat = (amt_ext > c_DW_CNT) ? c_DW_CNT : amt_ext;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      work_q      <= '0;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      sh_en_q     <= 1'b0;
      sh_fun_q    <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // cmd_ready_q is high throughout IDLE, so valid alone is the accept.
          if (cmd_valid_i) begin
            work_q      <= cmd_data_i;
            dir_q       <= cmd_dir_i;
            remaining_q <= amt_sat;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (amt_sat == '0) begin
              res_data_q  <= cmd_data_i;
              res_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              sh_en_q  <= 1'b1;
              sh_fun_q <= ALU_FUN_WIDTH'(cmd_dir_i);
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          sh_en_q  <= 1'b0;
          sh_fun_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (sh_out_valid_i) begin
            work_q      <= sh_out_i;
            remaining_q <= remaining_q - 1'b1;
            if (remaining_q == c_CNT_W'(1)) begin
              // Result is taken straight from the unit so it is valid
              // together with the completion pulse.
              res_data_q  <= sh_out_i;
              res_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              sh_en_q  <= 1'b1;
              sh_fun_q <= ALU_FUN_WIDTH'(dir_q);
              state_q  <= S_ISSUE;
            end
          end
        end
        S_DONE: begin
          res_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // sh_en_q is high exactly in ISSUE, so this keeps A at zero elsewhere.
  assign sh_a_o      = sh_en_q ? work_q : '0;
  assign sh_b_o      = '0;
  assign sh_fun_o    = sh_fun_q;
  assign sh_en_o     = sh_en_q;
  assign res_data_o  = res_data_q;
  assign res_valid_o = res_valid_q;
  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_sequencer
// Purpose  : Self-checking bench for shift_sequencer with a behavioural
//            single-bit shift unit of programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [DW-1:0] cmd_data;
  logic          cmd_dir;
  logic [AW-1:0] cmd_amt;
  logic [DW-1:0] sh_a;
  logic [DW-1:0] sh_b;
  logic [FW-1:0] sh_fun;
  logic          sh_en;
  logic [DW-1:0] sh_out;
  logic          sh_out_valid;
  logic [DW-1:0] res_data;
  logic          res_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int lat    = 1;

  always #5 clk = ~clk;

  shift_sequencer #(
    .DATA_WIDTH   (DW),
    .AMT_WIDTH    (AW),
    .ALU_FUN_WIDTH(FW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_data_i    (cmd_data),
    .cmd_dir_i     (cmd_dir),
    .cmd_amt_i     (cmd_amt),
    .sh_a_o        (sh_a),
    .sh_b_o        (sh_b),
    .sh_fun_o      (sh_fun),
    .sh_en_o       (sh_en),
    .sh_out_i      (sh_out),
    .sh_out_valid_i(sh_out_valid),
    .res_data_o    (res_data),
    .res_valid_o   (res_valid),
    .busy_o        (busy)
  );

  // Behavioural shift unit: result appears 'lat' edges after the enable edge.
  logic [DW-1:0] u_pend;
  int            u_cnt;

  function automatic logic [DW-1:0] unit_op(input logic [DW-1:0] a, input logic [FW-1:0] f);
    return f[0] ? (a << 1) : (a >> 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_out       <= '0;
      sh_out_valid <= 1'b0;
      u_pend       <= '0;
      u_cnt        <= 0;
    end else begin
      sh_out_valid <= 1'b0;
      if (sh_en) begin
        if (lat <= 1) begin
          sh_out       <= unit_op(sh_a, sh_fun);
          sh_out_valid <= 1'b1;
        end else begin
          u_pend <= unit_op(sh_a, sh_fun);
          u_cnt  <= lat - 1;
        end
      end else if (u_cnt != 0) begin
        u_cnt <= u_cnt - 1;
        if (u_cnt == 1) begin
          sh_out       <= u_pend;
          sh_out_valid <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a logical shift by the full amount, zero-filled.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] d, input logic dir,
                                             input logic [AW-1:0] amt);
    logic [DW-1:0] r;
    r = dir ? (d << amt) : (d >> amt);
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_sh_en"},     32'(sh_en),     0);
    check({tag, "_sh_a"},      32'(sh_a),      0);
    check({tag, "_sh_fun"},    32'(sh_fun),    0);
    check({tag, "_sh_b"},      32'(sh_b),      0);
    check({tag, "_res_valid"}, 32'(res_valid), 0);
    check({tag, "_ready"},     32'(cmd_ready), 1);
    check({tag, "_busy"},      32'(busy),      0);
  endtask

  // One command; with keep set, cmd_valid stays high with the next command's
  // fields while this one is busy.
  task automatic run_cmd(input logic [DW-1:0] d, input logic dir, input logic [AW-1:0] amt,
                         input bit keep, input logic [DW-1:0] d2, input logic dir2,
                         input logic [AW-1:0] amt2);
    int            n;
    int            edges;
    int            pulses;
    logic [DW-1:0] w;
    logic [DW-1:0] expv;
    n      = (int'(amt) > DW) ? DW : int'(amt);
    expv   = ref_shift(d, dir, amt);
    w      = d;
    edges  = 0;
    pulses = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = d;
    cmd_dir   = dir;
    cmd_amt   = amt;
    check("ready_before_accept", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    if (keep) begin
      cmd_data = d2;
      cmd_dir  = dir2;
      cmd_amt  = amt2;
    end else begin
      cmd_valid = 1'b0;
    end
    while (!res_valid && edges < 400) begin
      if (sh_en) begin
        pulses++;
        check("sh_a_operand", 32'(sh_a), 32'(w));
        check("sh_fun_pulse", 32'(sh_fun), 32'({1'b0, dir}));
        w = dir ? (w << 1) : (w >> 1);
      end else begin
        check("sh_a_zero", 32'(sh_a), 0);
      end
      check("ready_busy", 32'(cmd_ready), 0);
      check("busy_high",  32'(busy), 1);
      @(posedge clk);
      #1;
      edges++;
    end
    check("res_valid_seen", 32'(res_valid), 1);
    check("latency", 32'(edges), 32'(n * (lat + 1)));
    check("sh_en_pulses", 32'(pulses), 32'(n));
    check("res_data", 32'(res_data), 32'(expv));
    check("done_busy", 32'(busy), 1);
    check("done_ready", 32'(cmd_ready), 0);
    check("done_sh_en", 32'(sh_en), 0);
    @(posedge clk);
    #1;
    check("pulse_one_cycle", 32'(res_valid), 0);
    check("idle_ready", 32'(cmd_ready), 1);
    check("idle_busy", 32'(busy), 0);
    check("res_data_held", 32'(res_data), 32'(expv));
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    cmd_dir   = 1'b0;
    cmd_amt   = '0;

    // Reset held three cycles, then released.
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("in_reset");
    check("in_reset_res_data", 32'(res_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("after_reset");
    check("after_reset_res_data", 32'(res_data), 0);

    // Directed commands.
    run_cmd(8'hB5, 1'b1, 4'd3,  1'b0, 8'h00, 1'b0, 4'd0);
    check("dir_left_b5", 32'(res_data), 32'h A8);
    run_cmd(8'hB5, 1'b0, 4'd2,  1'b0, 8'h00, 1'b0, 4'd0);
    check("dir_right_b5", 32'(res_data), 32'h 2D);
    run_cmd(8'h3C, 1'b0, 4'd0,  1'b0, 8'h00, 1'b0, 4'd0);
    check("amt_zero", 32'(res_data), 32'h 3C);
    run_cmd(8'hFF, 1'b1, 4'd12, 1'b0, 8'h00, 1'b0, 4'd0);
    check("amt_over", 32'(res_data), 32'h 00);
    run_cmd(8'h80, 1'b0, 4'd8,  1'b0, 8'h00, 1'b0, 4'd0);

    // Valid held high with different fields while busy.
    run_cmd(8'h5A, 1'b0, 4'd4,  1'b1, 8'h81, 1'b1, 4'd1);
    run_cmd(8'h81, 1'b1, 4'd1,  1'b0, 8'h00, 1'b0, 4'd0);
    check("held_cmd_result", 32'(res_data), 32'h 02);

    // Reset while waiting on the unit in an AMT=5 command.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = 8'h0F;
    cmd_dir   = 1'b1;
    cmd_amt   = 4'd5;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    check("in_wait_sh_en", 32'(sh_en), 0);
    check("in_wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    check("mid_reset_res_data", 32'(res_data), 0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_reset_no_pulse", 32'(res_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_idle_outputs("post_mid_reset");
    run_cmd(8'h96, 1'b0, 4'd3, 1'b0, 8'h00, 1'b0, 4'd0);

    // Randomized commands with varying unit latency.
    for (int i = 0; i < 24; i++) begin
      logic [DW-1:0] rd;
      logic          rdir;
      logic [AW-1:0] ramt;
      lat  = int'($urandom_range(1, 3));
      rd   = DW'($urandom);
      rdir = 1'($urandom);
      ramt = AW'($urandom);
      run_cmd(rd, rdir, ramt, 1'b0, 8'h00, 1'b0, 4'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
